// File: rtl/one_unit_pkg.sv
// Shared definitions for the one_unit accumulate/update datapath.
//   DATA_W    - sample/weight width, signed Q12.13
//   FRAC_W    - fraction bits of the Q12.13 format
//   ACC_W     - accumulator width (headroom for 2^12 full-scale samples)
//   LOG2N_MAX - largest supported log2 of the sample count
//   CNT_W     - sample counter width (must hold 2^LOG2N_MAX)
//   state_e   - accumulator FSM state encoding
package one_unit_pkg;

  localparam int DATA_W    = 26;
  localparam int FRAC_W    = 13;
  localparam int ACC_W     = 40;
  localparam int LOG2N_MAX = 12;
  localparam int CNT_W     = LOG2N_MAX + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Out-of-range sample-count exponents behave as the largest legal one.
  function automatic logic [3:0] clamp_log2n(input logic [3:0] l2);
    if (l2 > 4'(LOG2N_MAX)) return 4'(LOG2N_MAX);
    return l2;
  endfunction

endpackage

// File: rtl/one_unit_sat26.sv
// Combinational saturation of a wide two's-complement value to DATA_W bits.
//   din_i  [ACC_W-1:0]  - signed wide input
//   dout_o [DATA_W-1:0] - signed result clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]
module one_unit_sat26
  import one_unit_pkg::*;
(
  input  logic [ACC_W-1:0]  din_i,
  output logic [DATA_W-1:0] dout_o
);

  // The value fits when every bit from the result sign bit upward agrees.
  logic [ACC_W-DATA_W:0] top_bits;
  assign top_bits = din_i[ACC_W-1:DATA_W-1];

  always_comb begin
    dout_o = din_i[DATA_W-1:0];
    if (!((top_bits == '0) || (top_bits == '1))) begin
      if (din_i[ACC_W-1]) dout_o = {1'b1, {(DATA_W-1){1'b0}}};
      else                dout_o = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/one_unit_acc4.sv
// Four-lane sample accumulator producing the weight update mean(p) - 3*w.
// A pass starts with a one-cycle start pulse (latching log2n and w1..w4),
// accumulates 2^log2n accepted sample vectors, then spends one FIN cycle
// forming the saturated result, registered with a one-cycle out_valid pulse.
//
// Handshake: a sample is transferred on a rising clk_acc edge where
// in_valid and in_ready are both high; in_ready is high only in ACC, so
// in_valid is ignored in IDLE and FIN and gaps simply stall the count.
//
// Ports:
//   clk_acc, rst_acc       - clock, synchronous active-high reset
//   start, log2n, w1..w4   - pass request and its parameters
//   in_valid, p1..p4       - sample stream, in_ready back-pressure
//   busy                   - high in ACC and FIN (start ignored meanwhile)
//   wn1..wn4, out_valid    - updated weights, held until the next pulse
//   dbg_state_o            - current FSM state (state_e encoding)
module one_unit_acc4
  import one_unit_pkg::*;
(
  input  logic              clk_acc,
  input  logic              rst_acc,
  input  logic              start,
  input  logic [3:0]        log2n,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] w2,
  input  logic [DATA_W-1:0] w3,
  input  logic [DATA_W-1:0] w4,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] p1,
  input  logic [DATA_W-1:0] p2,
  input  logic [DATA_W-1:0] p3,
  input  logic [DATA_W-1:0] p4,
  output logic              in_ready,
  output logic              busy,
  output logic [DATA_W-1:0] wn1,
  output logic [DATA_W-1:0] wn2,
  output logic [DATA_W-1:0] wn3,
  output logic [DATA_W-1:0] wn4,
  output logic              out_valid,
  output logic [1:0]        dbg_state_o
);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q [4];
  logic signed [ACC_W-1:0]  acc_d [4];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               log2n_q, log2n_d;
  logic [DATA_W-1:0]        w_q [4];
  logic [DATA_W-1:0]        w_d [4];
  logic [DATA_W-1:0]        wn_q [4];
  logic [DATA_W-1:0]        wn_d [4];
  logic                     out_valid_q, out_valid_d;

  logic [DATA_W-1:0]        p_in [4];
  logic [DATA_W-1:0]        w_in [4];
  logic signed [ACC_W-1:0]  w_ext [4];
  logic signed [ACC_W-1:0]  diff [4];
  logic [DATA_W-1:0]        sat_out [4];
  logic [CNT_W-1:0]         target;
  logic [CNT_W-1:0]         cnt_inc;

  assign p_in[0] = p1;
  assign p_in[1] = p2;
  assign p_in[2] = p3;
  assign p_in[3] = p4;
  assign w_in[0] = w1;
  assign w_in[1] = w2;
  assign w_in[2] = w3;
  assign w_in[3] = w4;

  // 2^log2n fits in CNT_W bits because log2n_q never exceeds LOG2N_MAX.
  assign target  = CNT_W'(1) << log2n_q;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Result path: arithmetic shift floors toward -inf; 3*w = 2*w + w.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_ext[k] = {{(ACC_W-DATA_W){w_q[k][DATA_W-1]}}, w_q[k]};
      diff[k]  = (acc_q[k] >>> log2n_q) - ((w_ext[k] <<< 1) + w_ext[k]);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sat
    one_unit_sat26 u_sat (
      .din_i  (diff[g]),
      .dout_o (sat_out[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    log2n_d     = log2n_q;
    w_d         = w_q;
    wn_d        = wn_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int k = 0; k < 4; k++) begin
            acc_d[k] = '0;
            w_d[k]   = w_in[k];
          end
          cnt_d   = '0;
          log2n_d = clamp_log2n(log2n);
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          for (int k = 0; k < 4; k++) begin
            acc_d[k] = acc_q[k] + {{(ACC_W-DATA_W){p_in[k][DATA_W-1]}}, p_in[k]};
          end
          cnt_d = cnt_inc;
          if (cnt_inc == target) state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        wn_d        = sat_out;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_acc) begin
    if (rst_acc) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      log2n_q     <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        acc_q[k] <= '0;
        w_q[k]   <= '0;
        wn_q[k]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      log2n_q     <= log2n_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      w_q         <= w_d;
      wn_q        <= wn_d;
    end
  end

  assign in_ready    = (state_q == ST_ACC);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = out_valid_q;
  assign wn1         = wn_q[0];
  assign wn2         = wn_q[1];
  assign wn3         = wn_q[2];
  assign wn4         = wn_q[3];
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_one_unit_acc4.sv
// Directed bench for one_unit_acc4: inputs change and outputs are sampled on
// the falling edge, half a period away from the active rising edge.
module tb_one_unit_acc4;
  import one_unit_pkg::*;

  logic        clk_acc = 1'b0;
  logic        rst_acc;
  logic        start;
  logic [3:0]  log2n;
  logic [25:0] w1, w2, w3, w4;
  logic        in_valid;
  logic [25:0] p1, p2, p3, p4;
  logic        in_ready, busy, out_valid;
  logic [25:0] wn1, wn2, wn3, wn4;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [25:0] exp_q[$];

  one_unit_acc4 dut (
    .clk_acc     (clk_acc),
    .rst_acc     (rst_acc),
    .start       (start),
    .log2n       (log2n),
    .w1          (w1),
    .w2          (w2),
    .w3          (w3),
    .w4          (w4),
    .in_valid    (in_valid),
    .p1          (p1),
    .p2          (p2),
    .p3          (p3),
    .p4          (p4),
    .in_ready    (in_ready),
    .busy        (busy),
    .wn1         (wn1),
    .wn2         (wn2),
    .wn3         (wn3),
    .wn4         (wn4),
    .out_valid   (out_valid),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk_acc = ~clk_acc;

  task automatic tick();
    @(negedge clk_acc);
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input logic [3:0] l2, input logic [25:0] a, b, c, d);
    start = 1'b1; log2n = l2; w1 = a; w2 = b; w3 = c; w4 = d;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [25:0] a, b, c, d);
    in_valid = 1'b1; p1 = a; p2 = b; p3 = c; p4 = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [25:0] a, b, c, d);
    exp_q.push_back(a); exp_q.push_back(b);
    exp_q.push_back(c); exp_q.push_back(d);
  endtask

  // Called right after the tick that accepts the last sample: FIN cycle,
  // then the out_valid cycle, then a cycle proving the result is held.
  task automatic expect_result(input string tag);
    logic [25:0] e [4];
    check({tag, "_fin_ov"},    {39'b0, out_valid}, 40'd0);
    check({tag, "_fin_ready"}, {39'b0, in_ready},  40'd0);
    check({tag, "_fin_busy"},  {39'b0, busy},      40'd1);
    tick();
    for (int k = 0; k < 4; k++) e[k] = exp_q.pop_front();
    check({tag, "_ov"},  {39'b0, out_valid}, 40'd1);
    check({tag, "_wn1"}, {14'b0, wn1}, {14'b0, e[0]});
    check({tag, "_wn2"}, {14'b0, wn2}, {14'b0, e[1]});
    check({tag, "_wn3"}, {14'b0, wn3}, {14'b0, e[2]});
    check({tag, "_wn4"}, {14'b0, wn4}, {14'b0, e[3]});
    tick();
    check({tag, "_ov_pulse"},  {39'b0, out_valid}, 40'd0);
    check({tag, "_idle_busy"}, {39'b0, busy},      40'd0);
    check({tag, "_hold_wn1"},  {14'b0, wn1}, {14'b0, e[0]});
    check({tag, "_hold_wn4"},  {14'b0, wn4}, {14'b0, e[3]});
  endtask

  initial begin
    int acc_cnt;
    rst_acc = 1'b1; start = 1'b0; log2n = '0; in_valid = 1'b0;
    w1 = '0; w2 = '0; w3 = '0; w4 = '0;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;
    repeat (3) tick();

    // Reset state
    check("rst_ov",    {39'b0, out_valid}, 40'd0);
    check("rst_busy",  {39'b0, busy},      40'd0);
    check("rst_ready", {39'b0, in_ready},  40'd0);
    check("rst_wn1",   {14'b0, wn1},       40'd0);
    check("rst_state", {38'b0, dbg_state}, {38'b0, ST_IDLE});
    rst_acc = 1'b0;
    tick();

    // Mean only: 4 samples, w = 0. p3 sum -400 >>> 2 = -100.
    do_start(4'd2, 26'd0, 26'd0, 26'd0, 26'd0);
    check("mean_ready", {39'b0, in_ready}, 40'd1);
    repeat (4) send(26'd8192, 26'd100, 26'(-100), 26'd0);
    push_exp(26'd8192, 26'd100, 26'(-100), 26'd0);
    expect_result("mean");

    // -3w term, single sample (log2n = 0)
    do_start(4'd0, 26'd8192, 26'(-4096), 26'd0, 26'd100);
    send(26'd8192, 26'd0, 26'd5, 26'd0);
    push_exp(26'(-16384), 26'd12288, 26'd5, 26'(-300));
    expect_result("w3");

    // Saturation both ways
    do_start(4'd0, 26'(-33554432), 26'd33554431, 26'd0, 26'(-1000));
    send(26'd33554431, 26'(-33554432), 26'd0, 26'd1000);
    push_exp(26'd33554431, 26'(-33554432), 26'd0, 26'd4000);
    expect_result("sat");

    // Flow control: in_valid every other cycle with poison data in the gaps.
    // p1 ramp 8192..65536 -> 36864; p2 -1..-8 sums -36, >>>3 floors to -5.
    do_start(4'd3, 26'd0, 26'd0, 26'd0, 26'd0);
    acc_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      if (in_ready) acc_cnt++;
      send(26'(8192 * i), 26'(-i), 26'd0, 26'd7);
      p1 = 26'd123456; p2 = 26'd99; p3 = 26'd55; p4 = 26'd1;
      if (i < 8) tick();
    end
    check("fc_count", 40'(acc_cnt), 40'd8);
    check("fc_ready_after8", {39'b0, in_ready}, 40'd0);
    // A valid sample offered in FIN must not be taken.
    in_valid = 1'b1; p1 = 26'd1000000;
    push_exp(26'd36864, 26'(-5), 26'd0, 26'd7);
    expect_result("fc");
    in_valid = 1'b0;

    // Reset mid-pass: 3 of 4 samples, then reset -> no pulse, outputs zero.
    do_start(4'd2, 26'd8192, 26'd0, 26'd0, 26'd0);
    repeat (3) send(26'd8192, 26'd1, 26'd1, 26'd1);
    rst_acc = 1'b1;
    tick();
    rst_acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rstmid_ov", {39'b0, out_valid}, 40'd0);
      in_valid = 1'b1; p1 = 26'd8192;
      tick();
    end
    in_valid = 1'b0;
    check("rstmid_busy", {39'b0, busy}, 40'd0);
    check("rstmid_wn1",  {14'b0, wn1},  40'd0);
    check("rstmid_wn2",  {14'b0, wn2},  40'd0);
    check("rstmid_wn3",  {14'b0, wn3},  40'd0);
    check("rstmid_wn4",  {14'b0, wn4},  40'd0);

    // Reset wins over start in the same cycle.
    rst_acc = 1'b1; start = 1'b1; log2n = 4'd0;
    tick();
    rst_acc = 1'b0; start = 1'b0;
    check("rst_prio_busy", {39'b0, busy}, 40'd0);

    // Start during ACC ignored: (16384+16384)>>1 - 3*8192 = -8192.
    do_start(4'd1, 26'd8192, 26'd0, 26'd0, 26'd0);
    start = 1'b1; log2n = 4'd0; w1 = 26'd0;
    send(26'd16384, 26'd0, 26'd0, 26'd0);
    start = 1'b0;
    check("restart_busy", {39'b0, busy}, 40'd1);
    send(26'd16384, 26'd0, 26'd0, 26'd0);
    push_exp(26'(-8192), 26'd0, 26'd0, 26'd0);
    expect_result("restart");

    // Truncation toward -inf: -1>>>1=-1, 3>>>1=1, -3>>>1=-2.
    do_start(4'd1, 26'd0, 26'd0, 26'd0, 26'd0);
    send(26'(-1), 26'd3, 26'(-3), 26'd0);
    send(26'd0, 26'd0, 26'd0, 26'd0);
    push_exp(26'(-1), 26'd1, 26'(-2), 26'd0);
    expect_result("trunc");

    // log2n = 15 behaves as 12: pass lasts exactly 4096 samples.
    do_start(4'd15, 26'd0, 26'd0, 26'd0, 26'd0);
    for (int i = 0; i < 4095; i++) send(26'd1, 26'd2, 26'd0, 26'd0);
    check("clamp_ready_4095", {39'b0, in_ready}, 40'd1);
    send(26'd1, 26'd2, 26'd0, 26'd0);
    push_exp(26'd1, 26'd2, 26'd0, 26'd0);
    expect_result("clamp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
